// File: rtl/tile_renderer_anim.sv
// Per-tile pixel renderer for the VGA tile layer.
// Classifies each in-tile pixel as background/floor/gift/hole and emits colour, request and
// type with a fixed two-clock latency. Gifts blink on a frame counter; holes can flash an
// alert colour for a programmable number of frames.
// Optional build macro FLOOR_STRIPE_EN: floor drawn as scrolling 4-pixel stripes.
module tile_renderer_anim #(
    parameter int unsigned FLOOR_X0     = 10,
    parameter int unsigned FLOOR_X1     = 70,
    parameter int unsigned FLOOR_Y0     = 50,
    parameter int unsigned FLOOR_Y1     = 75,
    parameter int unsigned OBJ_X0       = 20,
    parameter int unsigned OBJ_X1       = 40,
    parameter int unsigned OBJ_Y0       = 20,
    parameter int unsigned OBJ_Y1       = 40,
    parameter int unsigned BLINK_FRAMES = 16,
    parameter int unsigned ALERT_FRAMES = 60,
    parameter logic [7:0]  FLOOR_RGB    = 8'hA1,
    parameter logic [7:0]  GIFT_RGB     = 8'hBB,
    parameter logic [7:0]  HOLE_RGB     = 8'hF1,
    parameter logic [7:0]  ALERT_RGB    = 8'hE0,
    parameter logic [7:0]  STRIPE_RGB   = 8'h80
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    input  logic [1:0]  tileType,
    input  logic        alertReq,
    output logic        drawingRequest,
    output logic [1:0]  drawingType,
    output logic [7:0]  RGBout,
    output logic        alertActive
);
    localparam int unsigned    FrameMod  = 2 * BLINK_FRAMES;
    localparam int unsigned    FcW       = $clog2(FrameMod);
    localparam logic [FcW-1:0] FrameLast = FcW'(FrameMod - 1);
    localparam logic [7:0]     AlertLoad = 8'(ALERT_FRAMES - 1);
    localparam logic [10:0]    FX0 = 11'(FLOOR_X0);
    localparam logic [10:0]    FX1 = 11'(FLOOR_X1);
    localparam logic [10:0]    FY0 = 11'(FLOOR_Y0);
    localparam logic [10:0]    FY1 = 11'(FLOOR_Y1);
    localparam logic [10:0]    OX0 = 11'(OBJ_X0);
    localparam logic [10:0]    OX1 = 11'(OBJ_X1);
    localparam logic [10:0]    OY0 = 11'(OBJ_Y0);
    localparam logic [10:0]    OY1 = 11'(OBJ_Y1);

    typedef enum logic {StIdle, StAlert} state_e;

    state_e         state_q, state_d;
    logic [FcW-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]     alert_cnt_q, alert_cnt_d;
    logic           flash_phase_q, flash_phase_d;
    logic           alert_active_q;

    // Stage 1: region class (tileType encoding) plus animation snapshot
    logic [1:0]     class_q, class_d;
    logic           gift_vis_q, gift_vis_d;
    logic           flash_on_q, flash_on_d;
`ifdef FLOOR_STRIPE_EN
    logic           stripe_q, stripe_d;
    logic [10:0]    stripe_sum;
`endif

    // Stage 2: pixel outputs
    logic [7:0]     rgb_q, rgb_d;
    logic           req_q, req_d;
    logic [1:0]     type_q, type_d;

    logic           in_floor, in_obj;

    // Frame counter for the gift blink cycle
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (startOfFrame) begin
            frame_cnt_d = (frame_cnt_q == FrameLast) ? '0 : frame_cnt_q + 1'b1;
        end
    end

    // Alert FSM next state; a request always (re)starts the sequence
    always_comb begin
        state_d       = state_q;
        alert_cnt_d   = alert_cnt_q;
        flash_phase_d = flash_phase_q;
        unique case (state_q)
            StIdle: begin
                if (alertReq) begin
                    state_d       = StAlert;
                    alert_cnt_d   = AlertLoad;
                    flash_phase_d = 1'b1;
                end
            end
            StAlert: begin
                if (alertReq) begin
                    alert_cnt_d   = AlertLoad;
                    flash_phase_d = 1'b1;
                end else if (startOfFrame) begin
                    if (alert_cnt_q != 8'd0) begin
                        alert_cnt_d   = alert_cnt_q - 8'd1;
                        flash_phase_d = ~flash_phase_q;
                    end else begin
                        state_d       = StIdle;
                        flash_phase_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stage 1 classification in priority order, strict unsigned bounds
    always_comb begin
        in_floor   = (offsetX > FX0) && (offsetX < FX1) && (offsetY > FY0) && (offsetY < FY1);
        in_obj     = (offsetX > OX0) && (offsetX < OX1) && (offsetY > OY0) && (offsetY < OY1);
        class_d    = 2'b00;
        if ((tileType != 2'b00) && in_floor) begin
            class_d = 2'b01;
        end else if ((tileType == 2'b10) && in_obj) begin
            class_d = 2'b10;
        end else if ((tileType == 2'b11) && in_obj) begin
            class_d = 2'b11;
        end
        gift_vis_d = (32'(frame_cnt_q) < BLINK_FRAMES);
        flash_on_d = (state_q == StAlert) && flash_phase_q;
`ifdef FLOOR_STRIPE_EN
        stripe_sum = offsetX + 11'(frame_cnt_q);
        stripe_d   = stripe_sum[2];
`endif
    end

    // Stage 2 colour, request and type from the stage 1 snapshot
    always_comb begin
        rgb_d  = 8'hFF;
        req_d  = 1'b0;
        type_d = 2'b00;
        case (class_q)
            2'b01: begin
`ifdef FLOOR_STRIPE_EN
                rgb_d = stripe_q ? STRIPE_RGB : FLOOR_RGB;
`else
                rgb_d = FLOOR_RGB;
`endif
                req_d  = 1'b1;
                type_d = 2'b01;
            end
            2'b10: begin
                if (gift_vis_q) begin
                    rgb_d  = GIFT_RGB;
                    req_d  = 1'b1;
                    type_d = 2'b10;
                end
            end
            2'b11: begin
                rgb_d  = flash_on_q ? ALERT_RGB : HOLE_RGB;
                req_d  = 1'b1;
                type_d = 2'b11;
            end
            default: ;
        endcase
    end

    // Animation state registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= StIdle;
            frame_cnt_q    <= '0;
            alert_cnt_q    <= 8'd0;
            flash_phase_q  <= 1'b0;
            alert_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            alert_cnt_q    <= alert_cnt_d;
            flash_phase_q  <= flash_phase_d;
            alert_active_q <= (state_q == StAlert);
        end
    end

    // Pixel pipeline registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            class_q    <= 2'b00;
            gift_vis_q <= 1'b0;
            flash_on_q <= 1'b0;
`ifdef FLOOR_STRIPE_EN
            stripe_q   <= 1'b0;
`endif
            rgb_q      <= 8'h00;
            req_q      <= 1'b0;
            type_q     <= 2'b00;
        end else begin
            class_q    <= class_d;
            gift_vis_q <= gift_vis_d;
            flash_on_q <= flash_on_d;
`ifdef FLOOR_STRIPE_EN
            stripe_q   <= stripe_d;
`endif
            rgb_q      <= rgb_d;
            req_q      <= req_d;
            type_q     <= type_d;
        end
    end

    assign RGBout         = rgb_q;
    assign drawingRequest = req_q;
    assign drawingType    = type_q;
    assign alertActive    = alert_active_q;

endmodule

// File: tb/tb_tile_renderer_anim.sv
// Bench for tile_renderer_anim (BLINK_FRAMES=2, ALERT_FRAMES=3): directed scenarios and random
// stimulus compared against a frame-level reference model.
module tb_tile_renderer_anim;
    localparam int B  = 2;
    localparam int AF = 3;

    typedef struct packed {
        logic [7:0] rgb;
        logic       req;
        logic [1:0] typ;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [1:0]  tileType;
    logic        alertReq;
    logic        drawingRequest;
    logic [1:0]  drawingType;
    logic [7:0]  RGBout;
    logic        alertActive;

    int total = 0;
    int bad   = 0;

    // Reference model state: blink position, alert running flag, frames since last request
    int   m_frames;
    logic m_alert_on;
    int   m_k;
    exp_t exp_q[$];

    tile_renderer_anim #(
        .BLINK_FRAMES (B),
        .ALERT_FRAMES (AF)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .tileType       (tileType),
        .alertReq       (alertReq),
        .drawingRequest (drawingRequest),
        .drawingType    (drawingType),
        .RGBout         (RGBout),
        .alertActive    (alertActive)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_pix(input logic [1:0] tt, input logic [10:0] ox,
                                       input logic [10:0] oy);
        exp_t e;
        logic floor_in, obj_in;
        logic [10:0] s;
        floor_in = (ox > 10) && (ox < 70) && (oy > 50) && (oy < 75);
        obj_in   = (ox > 20) && (ox < 40) && (oy > 20) && (oy < 40);
        e = '{rgb: 8'hFF, req: 1'b0, typ: 2'b00};
        s = ox + 11'(m_frames);
        if (tt != 2'b00 && floor_in) begin
`ifdef FLOOR_STRIPE_EN
            e = '{rgb: (s[2] ? 8'h80 : 8'hA1), req: 1'b1, typ: 2'b01};
`else
            e = '{rgb: 8'hA1, req: 1'b1, typ: 2'b01};
`endif
        end else if (tt == 2'b10 && obj_in) begin
            if (m_frames < B) e = '{rgb: 8'hBB, req: 1'b1, typ: 2'b10};
        end else if (tt == 2'b11 && obj_in) begin
            e = '{rgb: ((m_alert_on && (m_k % 2 == 0)) ? 8'hE0 : 8'hF1), req: 1'b1, typ: 2'b11};
        end
        return e;
    endfunction

    task automatic model_reset();
        m_frames   = 0;
        m_alert_on = 1'b0;
        m_k        = 0;
        exp_q.delete();
    endtask

    // Drive one clock of stimulus; return the expectation now due at the outputs
    task automatic tick(input logic sof, input logic alr, input logic [1:0] tt,
                        input logic [10:0] ox, input logic [10:0] oy,
                        output logic have, output exp_t e, output logic e_act);
        logic act_before;
        startOfFrame = sof;
        alertReq     = alr;
        tileType     = tt;
        offsetX      = ox;
        offsetY      = oy;
        exp_q.push_back(model_pix(tt, ox, oy));
        act_before = m_alert_on;
        @(posedge clk);
        #1;
        if (alr) begin
            m_alert_on = 1'b1;
            m_k        = 0;
        end else if (sof && m_alert_on) begin
            m_k++;
            if (m_k >= AF) m_alert_on = 1'b0;
        end
        if (sof) m_frames = (m_frames + 1) % (2 * B);
        e_act = act_before;
        if (exp_q.size() >= 2) begin
            e    = exp_q.pop_front();
            have = 1'b1;
        end else begin
            e    = '0;
            have = 1'b0;
        end
        startOfFrame = 1'b0;
        alertReq     = 1'b0;
    endtask

    task automatic apply_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic have, act;
        exp_t e;
        tick(1'b0, 1'b1, 2'b11, 11'd30, 11'd30, have, e, act);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 2'b11, 11'd30, 11'd30, have, e, act);
        resetN = 1'b0;
        #2;
        total++;
        if (RGBout !== 8'h00 || drawingRequest !== 1'b0 || drawingType !== 2'b00
            || alertActive !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got rgb=%h req=%b type=%b act=%b, want 00/0/00/0",
                     RGBout, drawingRequest, drawingType, alertActive);
        end
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 2'b00, 11'd30, 11'd30, have, e, act);
            if (have) begin
                total++;
                if (RGBout !== 8'hFF || drawingRequest !== 1'b0 || drawingType !== 2'b00
                    || alertActive !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_release: got rgb=%h req=%b type=%b act=%b, want FF/0/00/0",
                             RGBout, drawingRequest, drawingType, alertActive);
                end
            end
        end
    endtask

    task automatic test_floor_priority();
        logic have, act;
        exp_t e;
        logic [10:0] ys [4];
        ys = '{11'd60, 11'd60, 11'd50, 11'd50};
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 2'b10, 11'd30, ys[i % 4], have, e, act);
            if (have) begin
                total++;
                if (RGBout !== e.rgb || drawingRequest !== e.req || drawingType !== e.typ) begin
                    bad++;
                    $display("FAIL floor_priority y=%0d: got %h/%b/%b, want %h/%b/%b",
                             ys[(i + 3) % 4], RGBout, drawingRequest, drawingType,
                             e.rgb, e.req, e.typ);
                end
            end
        end
        // (30,60) gift tile lands in the floor band; (30,50) sits on the band edge
        tick(1'b0, 1'b0, 2'b10, 11'd30, 11'd60, have, e, act);
        tick(1'b0, 1'b0, 2'b10, 11'd30, 11'd60, have, e, act);
        total++;
        if (RGBout !== 8'hA1 || drawingRequest !== 1'b1 || drawingType !== 2'b01) begin
            bad++;
            $display("FAIL floor_inside: got %h/%b/%b, want A1/1/01",
                     RGBout, drawingRequest, drawingType);
        end
        tick(1'b0, 1'b0, 2'b10, 11'd30, 11'd50, have, e, act);
        tick(1'b0, 1'b0, 2'b10, 11'd30, 11'd50, have, e, act);
        tick(1'b0, 1'b0, 2'b10, 11'd30, 11'd50, have, e, act);
        total++;
        if (RGBout !== 8'hFF || drawingRequest !== 1'b0 || drawingType !== 2'b00) begin
            bad++;
            $display("FAIL floor_edge: got %h/%b/%b, want FF/0/00",
                     RGBout, drawingRequest, drawingType);
        end
    endtask

    task automatic test_gift_blink();
        logic have, act;
        exp_t e;
        logic vis;
        apply_reset();
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 3; i++) begin
                tick(1'b0, 1'b0, 2'b10, 11'd30, 11'd30, have, e, act);
                if (have) begin
                    total++;
                    if (RGBout !== e.rgb || drawingRequest !== e.req || drawingType !== e.typ) begin
                        bad++;
                        $display("FAIL gift_model f=%0d: got %h/%b/%b, want %h/%b/%b", f,
                                 RGBout, drawingRequest, drawingType, e.rgb, e.req, e.typ);
                    end
                end
            end
            vis = ((f % 4) < 2);
            total++;
            if (RGBout !== (vis ? 8'hBB : 8'hFF) || drawingRequest !== vis) begin
                bad++;
                $display("FAIL gift_blink frame=%0d: got rgb=%h req=%b, want rgb=%h req=%b", f,
                         RGBout, drawingRequest, vis ? 8'hBB : 8'hFF, vis);
            end
            tick(1'b1, 1'b0, 2'b10, 11'd30, 11'd30, have, e, act);
        end
    endtask

    task automatic test_alert();
        logic have, act;
        exp_t e;
        logic [7:0] lit [4];
        lit = '{8'hE0, 8'hF1, 8'hE0, 8'hF1};
        apply_reset();
        tick(1'b0, 1'b1, 2'b11, 11'd30, 11'd30, have, e, act);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 3; i++) begin
                tick(1'b0, 1'b0, 2'b11, 11'd30, 11'd30, have, e, act);
                if (have) begin
                    total++;
                    if (RGBout !== e.rgb || drawingType !== e.typ || alertActive !== act) begin
                        bad++;
                        $display("FAIL alert_model p=%0d: got %h/%b act=%b, want %h/%b act=%b",
                                 p, RGBout, drawingType, alertActive, e.rgb, e.typ, act);
                    end
                end
            end
            total++;
            if (RGBout !== lit[p] || alertActive !== (p < 3)) begin
                bad++;
                $display("FAIL alert_seq phase=%0d: got rgb=%h act=%b, want rgb=%h act=%b", p,
                         RGBout, alertActive, lit[p], (p < 3));
            end
            tick(1'b1, 1'b0, 2'b11, 11'd30, 11'd30, have, e, act);
        end
    endtask

    task automatic test_alert_restart();
        logic have, act;
        exp_t e;
        apply_reset();
        tick(1'b0, 1'b1, 2'b11, 11'd30, 11'd30, have, e, act);
        tick(1'b1, 1'b0, 2'b11, 11'd30, 11'd30, have, e, act);
        tick(1'b1, 1'b0, 2'b11, 11'd30, 11'd30, have, e, act);
        // Counter is at zero here: without the restart this frame pulse would end the alert
        tick(1'b1, 1'b1, 2'b11, 11'd30, 11'd30, have, e, act);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 2'b11, 11'd30, 11'd30, have, e, act);
        total++;
        if (RGBout !== 8'hE0 || alertActive !== 1'b1) begin
            bad++;
            $display("FAIL restart_reload: got rgb=%h act=%b, want E0 act=1", RGBout, alertActive);
        end
        tick(1'b1, 1'b0, 2'b11, 11'd30, 11'd30, have, e, act);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 2'b11, 11'd30, 11'd30, have, e, act);
        total++;
        if (RGBout !== 8'hF1 || alertActive !== 1'b1) begin
            bad++;
            $display("FAIL restart_count: got rgb=%h act=%b, want F1 act=1", RGBout, alertActive);
        end
    endtask

    task automatic test_back_to_back();
        logic have, act;
        exp_t e;
        logic [1:0]  tts [8];
        logic [10:0] xs  [8];
        logic [10:0] yss [8];
        apply_reset();
        tts = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b10};
        xs  = '{11'd30, 11'd30, 11'd30, 11'd30, 11'd30, 11'd40, 11'd11, 11'd69};
        yss = '{11'd30, 11'd60, 11'd30, 11'd30, 11'd50, 11'd30, 11'd51, 11'd74};
        for (int i = 0; i < 10; i++) begin
            if (i < 8) tick(1'b0, 1'b0, tts[i], xs[i], yss[i], have, e, act);
            else tick(1'b0, 1'b0, 2'b00, 11'd0, 11'd0, have, e, act);
            if (have) begin
                total++;
                if (RGBout !== e.rgb || drawingRequest !== e.req || drawingType !== e.typ) begin
                    bad++;
                    $display("FAIL back_to_back idx=%0d: got %h/%b/%b, want %h/%b/%b", i - 1,
                             RGBout, drawingRequest, drawingType, e.rgb, e.req, e.typ);
                end
            end
        end
    endtask

    task automatic test_random();
        logic have, act, sof, alr;
        exp_t e;
        logic [10:0] ox, oy;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            sof = ($urandom_range(0, 7) == 0);
            alr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) begin
                ox = 11'($urandom);
                oy = 11'($urandom);
            end else begin
                ox = 11'($urandom_range(0, 90));
                oy = 11'($urandom_range(0, 90));
            end
            tick(sof, alr, 2'($urandom), ox, oy, have, e, act);
            if (have) begin
                total++;
                if (RGBout !== e.rgb || drawingRequest !== e.req || drawingType !== e.typ
                    || alertActive !== act) begin
                    bad++;
                    $display("FAIL random i=%0d: got %h/%b/%b act=%b, want %h/%b/%b act=%b", i,
                             RGBout, drawingRequest, drawingType, alertActive,
                             e.rgb, e.req, e.typ, act);
                end
            end
        end
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        alertReq     = 1'b0;
        tileType     = 2'b00;
        offsetX      = 11'd0;
        offsetY      = 11'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b1;
        test_reset();
        test_floor_priority();
        test_gift_blink();
        test_alert();
        test_alert_restart();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
